// File: rtl/lut_layer_rt.sv
// Runtime-loadable layer of LUT neurons: per-neuron truth tables in distributed RAM,
// written over a config port, with a one-cycle registered lookup behind valid/ready.
module lut_layer_rt #(
    parameter  int IN_BITS     = 2,
    parameter  int FAN_IN      = 4,
    parameter  int OUT_BITS    = 2,
    parameter  int NUM_NEURONS = 8,
    localparam int ADDR_W      = IN_BITS * FAN_IN,
    localparam int NID_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [NUM_NEURONS*ADDR_W-1:0]   s_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0] m_data,
    input  logic                            cfg_start,
    input  logic                            cfg_we,
    input  logic [NID_W-1:0]                cfg_neuron,
    input  logic [ADDR_W-1:0]               cfg_addr,
    input  logic [OUT_BITS-1:0]             cfg_data,
    input  logic                            cfg_done,
    output logic                            active,
    output logic                            cfg_err
);

    localparam int             DEPTH    = 1 << ADDR_W;
    localparam logic [NID_W:0] NUM_N_L  = (NID_W+1)'(NUM_NEURONS);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t                            state_q, state_d;
    logic                              m_valid_q, m_valid_d;
    logic [NUM_NEURONS*OUT_BITS-1:0]   m_data_q, m_data_d;
    logic                              cfg_err_q, cfg_err_d;
    logic                              active_q, active_d;
    logic [NUM_NEURONS*OUT_BITS-1:0]   lookup_s;
    logic                              accept_s;
    logic                              nid_ok_s;
    logic                              wr_en_s;
    logic [OUT_BITS-1:0]               tbl_q [NUM_NEURONS][DEPTH];

    assign s_ready  = (state_q == ST_ACTIVE) && (!m_valid_q || m_ready);
    assign accept_s = s_valid && s_ready;
    assign nid_ok_s = ({1'b0, cfg_neuron} < NUM_N_L);
    assign wr_en_s  = cfg_we && (state_q == ST_LOAD) && nid_ok_s;

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign active   = active_q;
    assign cfg_err  = cfg_err_q;

    // Table RAM: write-only from the config port, deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            tbl_q[cfg_neuron][cfg_addr] <= cfg_data;
        end
    end

    // Per-neuron asynchronous table read for the current input beat
    always_comb begin
        lookup_s = '0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            lookup_s[n*OUT_BITS +: OUT_BITS] = tbl_q[n][s_data[n*ADDR_W +: ADDR_W]];
        end
    end

    // Mode sequencing; DRAIN waits for the pending result to leave before reloading
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (cfg_start) state_d = ST_LOAD;
                else           state_d = ST_EMPTY;
            end
            ST_LOAD: begin
                if (cfg_done) state_d = ST_ACTIVE;
                else          state_d = ST_LOAD;
            end
            ST_ACTIVE: begin
                if (cfg_start) state_d = ST_DRAIN;
                else           state_d = ST_ACTIVE;
            end
            ST_DRAIN: begin
                if (!m_valid_q) state_d = ST_LOAD;
                else            state_d = ST_DRAIN;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Output stage next-state, sticky config error, and registered mode flag
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (accept_s) begin
            m_valid_d = 1'b1;
            m_data_d  = lookup_s;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end

        if (cfg_we && ((state_q != ST_LOAD) || !nid_ok_s)) begin
            cfg_err_d = 1'b1;
        end else begin
            cfg_err_d = cfg_err_q;
        end

        active_d = (state_d == ST_ACTIVE);
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            cfg_err_q <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            cfg_err_q <= cfg_err_d;
            active_q  <= active_d;
        end
    end

endmodule

// File: tb/tb_lut_layer_rt.sv
// Directed bench for lut_layer_rt: reset, load, latency/throughput, hold, drain,
// illegal config write, randomized stream against a reference table, async reset.
module tb_lut_layer_rt;

    localparam int NN = 8;
    localparam int AW = 8;
    localparam int OB = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [NN*AW-1:0]  s_data = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [NN*OB-1:0]  m_data;
    logic              cfg_start = 1'b0;
    logic              cfg_we = 1'b0;
    logic [2:0]        cfg_neuron = '0;
    logic [AW-1:0]     cfg_addr = '0;
    logic [OB-1:0]     cfg_data = '0;
    logic              cfg_done = 1'b0;
    logic              active;
    logic              cfg_err;

    logic [OB-1:0]     ref_tbl [NN][256];
    int                n_checks = 0;
    int                n_errors = 0;

    lut_layer_rt dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .cfg_start(cfg_start), .cfg_we(cfg_we), .cfg_neuron(cfg_neuron),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_done(cfg_done),
        .active(active), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [NN*OB-1:0] exp_of(input logic [NN*AW-1:0] d);
        logic [NN*OB-1:0] r;
        r = '0;
        for (int n = 0; n < NN; n++) r[n*OB +: OB] = ref_tbl[n][d[n*AW +: AW]];
        return r;
    endfunction

    // Writes every entry of every neuron; cfg_done rides on the last write
    task automatic load_tables();
        for (int n = 0; n < NN; n++) begin
            for (int a = 0; a < 256; a++) begin
                cfg_we     = 1'b1;
                cfg_neuron = 3'(n);
                cfg_addr   = 8'(a);
                cfg_data   = ref_tbl[n][a];
                cfg_done   = (n == NN-1) && (a == 255);
                tick();
            end
        end
        cfg_we   = 1'b0;
        cfg_done = 1'b0;
    endtask

    initial begin
        logic [NN*AW-1:0] d0, d1, d2, d3, d4;
        logic [NN*OB-1:0] q[$];
        int acc, got, cyc;

        // Reset state
        repeat (3) tick();
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 16'h0);
        chk("rst_active", active, 1'b0);
        chk("rst_cfg_err", cfg_err, 1'b0);
        rst_n   = 1'b1;
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("empty_s_ready", s_ready, 1'b0);
            chk("empty_m_valid", m_valid, 1'b0);
            chk("empty_active", active, 1'b0);
        end
        s_valid = 1'b0;

        // First load: random tables with a few pinned entries on neuron 0
        for (int n = 0; n < NN; n++)
            for (int a = 0; a < 256; a++) ref_tbl[n][a] = 2'($urandom_range(0, 3));
        ref_tbl[0][8'h09] = 2'b11;
        ref_tbl[0][8'hE9] = 2'b01;
        ref_tbl[0][8'h00] = 2'b01;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("load_active", active, 1'b0);
        load_tables();
        chk("loaded_active", active, 1'b1);

        // Back-to-back beats, latency 1
        d0 = {$urandom, $urandom}; d0[7:0] = 8'h09;
        d1 = {$urandom, $urandom}; d1[7:0] = 8'hE9;
        s_valid = 1'b1; s_data = d0; m_ready = 1'b1;
        #1;
        chk("b2b_s_ready", s_ready, 1'b1);
        tick();
        s_data = d1;
        chk("b2b0_valid", m_valid, 1'b1);
        chk("b2b0_n0", m_data[1:0], 2'b11);
        chk("b2b0_data", m_data, exp_of(d0));
        tick();
        s_valid = 1'b0;
        chk("b2b1_valid", m_valid, 1'b1);
        chk("b2b1_n0", m_data[1:0], 2'b01);
        chk("b2b1_data", m_data, exp_of(d1));
        tick();
        chk("b2b_idle", m_valid, 1'b0);

        // Backpressure hold, then same-cycle release
        d2 = {$urandom, $urandom};
        d3 = {$urandom, $urandom};
        s_valid = 1'b1; s_data = d2; m_ready = 1'b0;
        tick();
        s_data = d3;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_valid", m_valid, 1'b1);
            chk("hold_data", m_data, exp_of(d2));
            chk("hold_s_ready", s_ready, 1'b0);
            tick();
        end
        m_ready = 1'b1;
        #1;
        chk("release_s_ready", s_ready, 1'b1);
        tick();
        s_valid = 1'b0;
        chk("release_data", m_data, exp_of(d3));
        tick();
        chk("release_idle", m_valid, 1'b0);

        // cfg_start with a pending, stalled result
        d4 = {$urandom, $urandom};
        s_valid = 1'b1; s_data = d4; m_ready = 1'b0;
        tick();
        s_valid = 1'b0; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("drain_active", active, 1'b0);
            chk("drain_s_ready", s_ready, 1'b0);
            chk("drain_data", m_data, exp_of(d4));
            tick();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        #1;
        chk("drain_deliver_valid", m_valid, 1'b1);
        chk("drain_deliver_data", m_data, exp_of(d4));
        tick();
        chk("drain_done_valid", m_valid, 1'b0);
        tick();
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        chk("reload_active", active, 1'b1);

        // Illegal write in ACTIVE
        chk("err_before", cfg_err, 1'b0);
        cfg_we = 1'b1; cfg_neuron = 3'd0; cfg_addr = 8'h00; cfg_data = 2'b10;
        tick();
        cfg_we = 1'b0;
        chk("err_set", cfg_err, 1'b1);
        s_valid = 1'b1; s_data = '0; m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("err_old_n0", m_data[1:0], 2'b01);
        chk("err_old_data", m_data, exp_of('0));
        tick();

        // Reload with fresh random tables, then a randomized stream
        for (int n = 0; n < NN; n++)
            for (int a = 0; a < 256; a++) ref_tbl[n][a] = 2'($urandom_range(0, 3));
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        tick();
        load_tables();
        chk("rand_active", active, 1'b1);
        chk("err_sticky", cfg_err, 1'b1);

        acc = 0; got = 0; cyc = 0;
        while ((acc < 1000 || q.size() != 0) && cyc < 20000) begin
            s_valid = (acc < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            s_data  = {$urandom, $urandom};
            m_ready = (acc < 1000) ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (m_valid && m_ready) begin
                if (q.size() == 0) chk("rand_dup", m_valid, 1'b0);
                else               chk("rand_data", m_data, q.pop_front());
                got++;
            end
            if (s_valid && s_ready) begin
                q.push_back(exp_of(s_data));
                acc++;
            end
            tick();
            cyc++;
        end
        s_valid = 1'b0;
        #1;
        chk("rand_accepted", 64'(acc), 64'd1000);
        chk("rand_delivered", 64'(got), 64'd1000);
        chk("rand_leftover", 64'(q.size()), 64'd0);
        chk("rand_final_idle", m_valid, 1'b0);

        // Async reset with a stalled beat pending
        s_valid = 1'b1; s_data = {$urandom, $urandom}; m_ready = 1'b0;
        tick();
        s_valid = 1'b0;
        chk("pre_rst_valid", m_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", m_valid, 1'b0);
        chk("async_rst_active", active, 1'b0);
        chk("async_rst_err", cfg_err, 1'b0);
        chk("async_rst_data", m_data, 16'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
